// File: rtl/cdc_pkg.sv
// Shared definitions for the sync/async clock-domain crossing blocks.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REQ,
    RTZ
  } s2a_state_t;

  localparam int unsigned CDC_DW          = 64;
  localparam int unsigned CDC_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module cdc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_s2a_tx.sv
// Sync-to-async transmitter: valid/ready FIFO feeding a bundled-data
// 4-phase (return-to-zero) request/acknowledge channel.
module cdc_s2a_tx
  import cdc_pkg::*;
#(
  parameter int unsigned DW          = CDC_DW,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [DW-1:0] Dout,
  output logic          So,
  input  logic          Si,
  output logic [31:0]   tx_count,
  output logic          busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  s2a_state_t    state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          so_q, so_d;
  logic [31:0]   tx_count_q, tx_count_d;
  logic          ack_s;
  logic          push;
  logic          pop;

  cdc_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (CLK),
    .rst_n(RESET),
    .d_in (Si),
    .d_out(ack_s)
  );

  // Ready depends only on the registered count, so a pop never frees a slot same-cycle.
  assign wr_ready = (count_q < CW'(DEPTH));
  assign push     = wr_valid && wr_ready;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    so_d       = so_q;
    tx_count_d = tx_count_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A high ack_s here is stale (e.g. held over reset), so no launch.
        if ((count_q != '0) && !ack_s) begin
          dout_d  = mem_q[rd_ptr_q];
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        so_d    = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        if (ack_s) begin
          so_d    = 1'b0;
          state_d = RTZ;
        end
      end
      RTZ: begin
        if (!ack_s) begin
          tx_count_d = tx_count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      so_q       <= 1'b0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      so_q       <= so_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign Dout     = dout_q;
  assign So       = so_q;
  assign tx_count = tx_count_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_cdc_s2a_tx.sv
// Self-checking bench for cdc_s2a_tx with a behavioural 4-phase receiver.
module tb_cdc_s2a_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned SS = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [DW-1:0] Dout;
  logic          So;
  logic          Si = 1'b0;
  logic [31:0]   tx_count;
  logic          busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [DW-1:0] exp_q [$];

  cdc_s2a_tx #(.DW(DW), .DEPTH(4), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RESET(RESET), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .Dout(Dout), .So(So), .Si(Si),
    .tx_count(tx_count), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Receiver side of one handshake: waits for So, checks the word against the
  // expected queue, acks after 'delay' cycles and verifies Dout holds until RTZ exits.
  task automatic handshake(input int unsigned delay, input string tag);
    int unsigned n;
    logic [DW-1:0] got, want;
    logic [31:0] tc0;
    logic moved;
    moved = 1'b0;
    tc0 = tx_count;
    n = 0;
    while (So !== 1'b1 && n < 300) begin @(negedge CLK); n++; end
    n_cmp++;
    if (So !== 1'b1) begin
      n_bad++; $display("FAIL %s_req_timeout So=%b want 1", tag, So); return;
    end
    got  = Dout;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL %s_data got=%h want=%h", tag, got, want);
    end
    repeat (delay) begin
      @(negedge CLK); if (Dout !== got) moved = 1'b1;
    end
    Si = 1'b1;
    n = 0;
    while (So !== 1'b0 && n < 50) begin
      @(negedge CLK); n++; if (Dout !== got) moved = 1'b1;
    end
    n_cmp++;
    if (So !== 1'b0) begin n_bad++; $display("FAIL %s_ack_timeout So=%b want 0", tag, So); end
    Si = 1'b0;
    n = 0;
    while (tx_count === tc0 && n < 50) begin
      @(negedge CLK); n++; if (Dout !== got) moved = 1'b1;
    end
    n_cmp++;
    if (tx_count !== tc0 + 32'd1) begin
      n_bad++; $display("FAIL %s_txcount got=%0d want=%0d", tag, tx_count, tc0 + 32'd1);
    end
    n_cmp++;
    if (moved !== 1'b0) begin
      n_bad++; $display("FAIL %s_dout_stable moved=%b want 0", tag, moved);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({So, Dout, tx_count, wr_ready, busy} !== {1'b0, 64'h0, 32'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset So=%b Dout=%h tx=%0d rdy=%b busy=%b want 0,0,0,1,0",
               So, Dout, tx_count, wr_ready, busy);
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] w;
    w = 64'h0123_4567_89AB_CDEF;
    wr_valid = 1'b1; wr_data = w;
    @(negedge CLK);               // edge E
    wr_valid = 1'b0;
    n_cmp++;
    if (Dout !== 64'h0 || So !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL lat_E Dout=%h So=%b busy=%b want 0,0,1", Dout, So, busy);
    end
    @(negedge CLK);               // E+1
    n_cmp++;
    if (Dout !== w || So !== 1'b0) begin
      n_bad++; $display("FAIL lat_E1 Dout=%h So=%b want %h,0", Dout, So, w);
    end
    @(negedge CLK);               // E+2
    n_cmp++;
    if (So !== 1'b1) begin n_bad++; $display("FAIL lat_E2_so So=%b want 1", So); end
    repeat (5) @(negedge CLK);
    Si = 1'b1;
    repeat (SS) @(negedge CLK);
    n_cmp++;
    if (So !== 1'b1) begin n_bad++; $display("FAIL ack_early So=%b want 1", So); end
    @(negedge CLK);
    n_cmp++;
    if (So !== 1'b0) begin n_bad++; $display("FAIL ack_fall So=%b want 0", So); end
    Si = 1'b0;
    repeat (SS) @(negedge CLK);
    n_cmp++;
    if (tx_count !== 32'd0) begin n_bad++; $display("FAIL rtz_early tx=%0d want 0", tx_count); end
    @(negedge CLK);
    n_cmp++;
    if (tx_count !== 32'd1 || Dout !== w) begin
      n_bad++; $display("FAIL rtz_done tx=%0d Dout=%h want 1,%h", tx_count, Dout, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = tx_count;
    Si = 1'b1;                    // stale ack blocks launching, FIFO fills
    repeat (SS + 1) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      logic [DW-1:0] w;
      w = {$urandom, $urandom};
      wr_valid = 1'b1; wr_data = w;
      if (i < 4) exp_q.push_back(w);
      @(negedge CLK);
      n_cmp++;
      if (wr_ready !== (i < 3)) begin
        n_bad++; $display("FAIL fill_ready_%0d got=%b want=%b", i, wr_ready, (i < 3));
      end
    end
    wr_valid = 1'b0;
    n_cmp++;
    if (So !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL fill_hold So=%b busy=%b want 0,1", So, busy);
    end
    Si = 1'b0;
    for (int i = 0; i < 4; i++) handshake(2, "b2b");
    n_cmp++;
    if (tx_count !== base + 32'd4 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_total tx=%0d busy=%b want %0d,0", tx_count, busy, base + 32'd4);
    end
  endtask

  task automatic test_stale_ack();
    logic [DW-1:0] w;
    logic early;
    Si = 1'b1;
    do_reset();
    w = {$urandom, $urandom};
    wr_valid = 1'b1; wr_data = w; exp_q.push_back(w);
    @(negedge CLK);
    wr_valid = 1'b0;
    early = 1'b0;
    repeat (8) begin @(negedge CLK); if (So !== 1'b0) early = 1'b1; end
    n_cmp++;
    if (early !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL stale_ack early=%b busy=%b want 0,1", early, busy);
    end
    Si = 1'b0;
    handshake(3, "stale");
  endtask

  task automatic test_reset_mid();
    int unsigned n;
    wr_valid = 1'b1; wr_data = {$urandom, $urandom};
    @(negedge CLK);
    wr_valid = 1'b1; wr_data = {$urandom, $urandom};
    @(negedge CLK);
    wr_valid = 1'b0;
    n = 0;
    while (So !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    n_cmp++;
    if ({So, Dout, tx_count, wr_ready, busy} !== {1'b0, 64'h0, 32'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset So=%b Dout=%h tx=%0d rdy=%b busy=%b want 0,0,0,1,0",
               So, Dout, tx_count, wr_ready, busy);
    end
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_walking_ones();
    logic [31:0] base;
    base = tx_count;
    fork
      begin : writer
        int unsigned k, guard;
        k = 0; guard = 0;
        while (k < 16 && guard < 5000) begin
          @(negedge CLK);
          guard++;
          if (wr_ready === 1'b1) begin
            logic [DW-1:0] w;
            w = 64'h1 << ((k * 4 + $urandom_range(0, 3)) % 64);
            wr_valid = 1'b1; wr_data = w; exp_q.push_back(w);
            k++;
          end else begin
            wr_valid = 1'b0;
          end
        end
        @(negedge CLK);
        wr_valid = 1'b0;
      end
      begin : receiver
        for (int i = 0; i < 16; i++) handshake($urandom_range(0, 20), "walk");
      end
    join
    n_cmp++;
    if (tx_count !== base + 32'd16 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL walk_total tx=%0d left=%0d want %0d,0",
                        tx_count, exp_q.size(), base + 32'd16);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] w;
    force dut.tx_count_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.tx_count_q;
    @(negedge CLK);
    n_cmp++;
    if (tx_count !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL wrap_preload tx=%h want ffffffff", tx_count);
    end
    w = {$urandom, $urandom};
    wr_valid = 1'b1; wr_data = w; exp_q.push_back(w);
    @(negedge CLK);
    wr_valid = 1'b0;
    handshake(4, "wrap");
    n_cmp++;
    if (tx_count !== 32'd0) begin n_bad++; $display("FAIL wrap_zero tx=%h want 0", tx_count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stale_ack();
    test_reset_mid();
    test_walking_ones();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
